// File: rtl/mult_rr_scheduler_if.sv
// Requester-side bus of the multiplier scheduler: job submission and response return.
interface mult_rr_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [2*WIDTH-1:0]    resp_product;
    logic                  resp_err;

    // Requester side
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_product, resp_err
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_product, resp_err
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one sequential multiplier core among NREQ requesters.
// Trivial operands (0 or 1) are answered without the core; core jobs that run past
// TIMEOUT cycles are aborted with an error response.
module mult_rr_scheduler #(
    parameter int NREQ    = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 300
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_rr_scheduler_if.slave  bus,
    output logic                mul_start,
    output logic [WIDTH-1:0]    mul_a,
    output logic [WIDTH-1:0]    mul_b,
    input  logic                mul_done,
    input  logic [2*WIDTH-1:0]  mul_product,
    output logic                busy
);
    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW = $clog2(TIMEOUT + 1);
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    cand;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  grant;
    logic             found;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin search for the first valid requester, starting one past the last winner
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = IW'((32'(ptr) + k) % NR);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        grant[gidx] = found;
    end

    // Operand pair of the requester being granted
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (IW'(i) == gidx) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign busy          = (state != IDLE);

    // Job FSM: accept, optional core issue/wait with abort budget, hold response until consumed.
    // The counter equals cycles elapsed since the mul_start cycle; the response registers
    // raise resp_valid on the first RESP cycle, so product/err are already settled when it rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= IW'(NREQ - 1);
            idx              <= '0;
            cnt              <= '0;
            mul_start        <= 1'b0;
            mul_a            <= '0;
            mul_b            <= '0;
            bus.resp_valid   <= '0;
            bus.resp_product <= '0;
            bus.resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx          <= gidx;
                        ptr          <= gidx;
                        bus.resp_err <= 1'b0;
                        if (sel_a == '0 || sel_b == '0) begin
                            bus.resp_product <= '0;
                            state            <= RESP;
                        end else if (sel_b == WIDTH'(1)) begin
                            bus.resp_product <= {{WIDTH{1'b0}}, sel_a};
                            state            <= RESP;
                        end else if (sel_a == WIDTH'(1)) begin
                            bus.resp_product <= {{WIDTH{1'b0}}, sel_b};
                            state            <= RESP;
                        end else begin
                            mul_a     <= sel_a;
                            mul_b     <= sel_b;
                            mul_start <= 1'b1;
                            cnt       <= '0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        bus.resp_product <= mul_product;
                        bus.resp_err     <= 1'b0;
                        state            <= RESP;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        bus.resp_product <= '0;
                        bus.resp_err     <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (|(bus.resp_valid & bus.resp_ready)) begin
                        bus.resp_valid <= '0;
                        state          <= IDLE;
                    end else begin
                        bus.resp_valid <= NREQ'(1) << idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction/timeline model of the scheduler.
module tb_mult_rr_scheduler;
    localparam int NREQ    = 2;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 300;
    localparam int PW      = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_done = 1'b0;
    logic [PW-1:0]    mul_product = '0;
    logic             busy;

    mult_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus knobs, applied at the next step
    logic [NREQ-1:0]  st_valid  = '0;
    logic [NREQ-1:0]  st_rready = '0;
    logic [WIDTH-1:0] st_a [NREQ];
    logic [WIDTH-1:0] st_b [NREQ];
    bit               force_stray = 0;
    int               next_lat    = 4;   // core latency for the next start; 0 = never answers

    // core model
    bit            core_busy = 0;
    int            core_due  = 0;
    logic [PW-1:0] core_res  = '0;

    // reference model: one job record plus the cycle numbers of its milestones
    bit               m_active  = 0;
    bit               m_core    = 0;
    int               m_idx     = 0;
    int               m_start   = 0;
    int               m_done_at = -1;
    int               m_resp_at = -1;
    int               m_ptr     = NREQ - 1;
    logic [WIDTH-1:0] m_a       = '0;
    logic [WIDTH-1:0] m_b       = '0;
    logic [PW-1:0]    m_prod    = '0;
    bit               m_err     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int grant_of(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return WIDTH'(1);
            2:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // One clock cycle: drive inputs, predict, compare at the falling edge, advance the model
    task automatic step();
        int          g;
        logic [31:0] e_ready, e_rv;
        bit          e_start, e_hold, in_wait;
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid  = st_valid;
        bus.resp_ready = st_rready;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = st_a[i];
            bus.req_b[i*WIDTH +: WIDTH] = st_b[i];
        end
        in_wait     = m_active && m_core && m_done_at < 0 && cyc > m_start;
        mul_done    = 1'b0;
        mul_product = PW'($urandom);
        if (core_busy && cyc == core_due) begin
            mul_done    = 1'b1;
            mul_product = core_res;
            core_busy   = 0;
        end else if (!in_wait && (force_stray || $urandom_range(0, 15) == 0)) begin
            mul_done = 1'b1;
        end
        g       = m_active ? -1 : grant_of(m_ptr, st_valid);
        e_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
        e_rv    = (m_active && m_resp_at >= 0 && cyc >= m_resp_at) ? (32'd1 << m_idx) : 32'd0;
        e_start = m_active && m_core && cyc == m_start;
        e_hold  = m_active && m_core && cyc >= m_start && (m_done_at < 0 || cyc <= m_done_at);
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), e_ready);
        check("resp_valid", 32'(bus.resp_valid), e_rv);
        check("mul_start", 32'(mul_start), 32'(e_start));
        check("busy", 32'(busy), 32'(m_active));
        if (e_rv != 0) begin
            check("resp_product", 32'(bus.resp_product), 32'(m_prod));
            check("resp_err", 32'(bus.resp_err), 32'(m_err));
        end
        if (e_hold) begin
            check("mul_a", 32'(mul_a), 32'(m_a));
            check("mul_b", 32'(mul_b), 32'(m_b));
        end
        if (mul_start) begin
            core_res = PW'(mul_a) * PW'(mul_b);
            if (next_lat > 0) begin
                core_busy = 1;
                core_due  = cyc + next_lat;
            end
        end
        if (!m_active) begin
            if (g >= 0) begin
                m_active  = 1;
                m_idx     = g;
                m_ptr     = g;
                m_a       = st_a[g];
                m_b       = st_b[g];
                m_err     = 0;
                m_done_at = -1;
                m_core    = !(m_a == 0 || m_b == 0 || m_a == 1 || m_b == 1);
                if (m_core) begin
                    m_start   = cyc + 1;
                    m_resp_at = -1;
                end else begin
                    m_prod    = (m_a == 0 || m_b == 0) ? PW'(0) : PW'(m_a) * PW'(m_b);
                    m_resp_at = cyc + 2;
                end
            end
        end else if (m_core && m_done_at < 0 && cyc > m_start) begin
            if (mul_done) begin
                m_prod    = PW'(m_a) * PW'(m_b);
                m_err     = 0;
                m_done_at = cyc;
                m_resp_at = cyc + 2;
            end else if (cyc == m_start + TIMEOUT) begin
                m_prod    = '0;
                m_err     = 1;
                m_done_at = cyc;
                m_resp_at = cyc + 2;
            end
        end else if (e_rv != 0 && st_rready[m_idx]) begin
            m_active = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        st_valid  = '0;
        st_rready = '1;
        repeat (n) step();
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic pulse_reset();
        st_valid = '0;
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid = '0;
        mul_done      = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_product", 32'(bus.resp_product), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        m_active = 0;
        m_ptr    = NREQ - 1;
        @(posedge clk);
        #1;
        cyc++;
        mul_done = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_acc;
        int          starts;
        logic [31:0] grants [4];
        int          ng;
        int          tbl [4][4];

        for (int i = 0; i < NREQ; i++) begin
            st_a[i] = '0;
            st_b[i] = '0;
        end
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_mul_start", 32'(mul_start), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_product", 32'(bus.resp_product), 32'd0);
        rst_n = 1'b1;

        // both requesters valid continuously: grants alternate starting with requester 0
        st_rready = '1;
        st_a[0] = '0; st_b[0] = 8'd5;
        st_a[1] = '0; st_b[1] = 8'd6;
        st_valid = 2'b11;
        ng = 0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            step();
            if (bus.req_ready != 0) begin
                grants[ng] = 32'(bus.req_ready);
                ng++;
            end
        end
        st_valid = '0;
        check("rr_grant0", grants[0], 32'h1);
        check("rr_grant1", grants[1], 32'h2);
        check("rr_grant2", grants[2], 32'h1);
        check("rr_grant3", grants[3], 32'h2);
        idle_cycles(4);

        // core job 12*10 with a 10-cycle core
        next_lat = 10;
        st_a[0] = 8'd12; st_b[0] = 8'd10;
        st_valid = 2'b01;
        step();
        check("core_accept", 32'(bus.req_ready), 32'h1);
        t_acc = cyc;
        st_valid = '0;
        starts = 0;
        for (int n = 0; n < 40 && bus.resp_valid == 0; n++) begin
            step();
            if (mul_start) starts++;
        end
        check("core_resp_valid", 32'(bus.resp_valid), 32'h1);
        check("core_product", 32'(bus.resp_product), 32'd120);
        check("core_err", 32'(bus.resp_err), 32'd0);
        check("core_starts", 32'(starts), 32'd1);
        check("core_latency", 32'(cyc - t_acc), 32'd13);
        idle_cycles(3);

        // trivial operands: answered two cycles after accept without the core
        tbl[0] = '{1, 200, 0, 0};
        tbl[1] = '{1, 37, 1, 37};
        tbl[2] = '{0, 1, 77, 77};
        tbl[3] = '{0, 0, 1, 0};
        for (int t = 0; t < 4; t++) begin
            st_a[tbl[t][0]] = WIDTH'(tbl[t][1]);
            st_b[tbl[t][0]] = WIDTH'(tbl[t][2]);
            st_valid = NREQ'(1) << tbl[t][0];
            step();
            check("triv_accept", 32'(bus.req_ready), 32'd1 << tbl[t][0]);
            st_valid = '0;
            step();
            check("triv_early_valid", 32'(bus.resp_valid), 32'd0);
            check("triv_no_start", 32'(mul_start), 32'd0);
            step();
            check("triv_resp_valid", 32'(bus.resp_valid), 32'd1 << tbl[t][0]);
            check("triv_product", 32'(bus.resp_product), 32'(tbl[t][3]));
            step();
        end
        idle_cycles(2);

        // core that never answers: abort with error, later stray done ignored
        next_lat = 0;
        st_rready = '0;
        st_a[0] = 8'd3; st_b[0] = 8'd5;
        st_valid = 2'b01;
        step();
        t_acc = cyc;
        st_valid = '0;
        for (int n = 0; n < TIMEOUT + 20 && bus.resp_valid == 0; n++) step();
        check("to_latency", 32'(cyc - t_acc), 32'(TIMEOUT + 3));
        check("to_err", 32'(bus.resp_err), 32'd1);
        check("to_product", 32'(bus.resp_product), 32'd0);
        repeat (4) step();
        force_stray = 1;
        step();
        force_stray = 0;
        repeat (2) step();
        check("to_stray_err", 32'(bus.resp_err), 32'd1);
        check("to_stray_product", 32'(bus.resp_product), 32'd0);
        idle_cycles(3);

        // full-width product held while the consumer stalls
        next_lat = 7;
        st_rready = '0;
        st_a[1] = 8'd255; st_b[1] = 8'd255;
        st_a[0] = '0;     st_b[0] = 8'd9;
        st_valid = 2'b10;
        step();
        check("hold_accept", 32'(bus.req_ready), 32'h2);
        st_valid = 2'b11;
        for (int n = 0; n < 30 && bus.resp_valid == 0; n++) step();
        for (int n = 0; n < 20; n++) begin
            step();
            check("hold_valid", 32'(bus.resp_valid), 32'h2);
            check("hold_product", 32'(bus.resp_product), 32'h0000FE01);
            check("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        st_rready = 2'b10;
        step();
        step();
        check("regrant_after_consume", 32'(bus.req_ready), 32'h1);
        idle_cycles(5);

        // reset during WAIT; the core's late done lands while idle
        next_lat = 40;
        st_a[0] = 8'd9; st_b[0] = 8'd9;
        st_valid = 2'b01;
        step();
        st_valid = '0;
        repeat (6) step();
        pulse_reset();
        idle_cycles(40);
        st_a[0] = '0; st_a[1] = '0;
        st_valid = 2'b11;
        step();
        check("post_reset_grant", 32'(bus.req_ready), 32'h1);
        idle_cycles(4);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            st_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                st_a[i]      = pick_operand();
                st_b[i]      = pick_operand();
                st_rready[i] = ($urandom_range(0, 9) < 7);
            end
            r = $urandom_range(0, 99);
            if (r < 2)      next_lat = 0;
            else if (r < 4) next_lat = TIMEOUT;
            else if (r < 6) next_lat = TIMEOUT - 1;
            else            next_lat = $urandom_range(1, 12);
            step();
        end
        idle_cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
